// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses, interrupt cause codes (also the mip/mie bit positions) and mstatus fields.
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MHPMEVENT_LO  = 12'h323;
    localparam logic [11:0] CSR_MHPMEVENT_HI  = 12'h33F;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MID_LO        = 12'hF11;
    localparam logic [11:0] CSR_MID_HI        = 12'hF14;
    localparam logic [11:0] CSR_MCNT_BASE     = 12'hB00;
    localparam logic [11:0] CSR_MCNTH_BASE    = 12'hB80;

    localparam int CAUSE_MSI    = 3;
    localparam int CAUSE_MTI    = 7;
    localparam int CAUSE_MEI    = 11;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] IRQ_MASK = (32'h1 << CAUSE_MSI) | (32'h1 << CAUSE_MTI) | (32'h1 << CAUSE_MEI);

    // Counter space: 0xB00-0xB1F, 0xB80-0xB9F, 0xC00-0xC1F, 0xC80-0xC9F; bit 7 picks the high half.
    function automatic logic is_cnt_addr(input logic [11:0] a);
        return (a[11:8] == 4'hB || a[11:8] == 4'hC) && (a[6:5] == 2'b00);
    endfunction
endpackage

// File: rtl/csr_counter.sv
// W-bit event counter with inhibit and 32-bit half writes; wraps from all-ones to zero.
// Increments and writes land on the next clk edge; a half write suppresses that cycle's increment.
module csr_counter #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        write_lo,
    input  logic        write_hi,
    input  logic [31:0] write_data,
    output logic [63:0] value
);
    logic [W-1:0] cnt;
    logic         unused_data;

    assign unused_data = ^write_data;
    assign value       = 64'(cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (write_lo || write_hi) begin
            if (write_lo) cnt[31:0]   <= write_data;
            if (write_hi) cnt[W-1:32] <= write_data[W-33:0];
        end else if (inc && !inhibit) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, writeback/trap/mret updates on the next clk edge.
// HPM counters exist only when CSR_HPM_EN is defined; otherwise their addresses read zero.
module csr_file import csr_pkg::*; #(
    parameter int          CNT_WIDTH    = 64,
    parameter int          NUM_HPM      = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          VECTORED     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] read_address,
    output logic [31:0] read_data,
    output logic        readable,
    output logic        writeable,
    input  logic        write_enable,
    input  logic [11:0] write_address,
    input  logic [31:0] write_data,
    input  logic        retired,
    input  logic        traped,
    input  logic        mret,
    input  logic [31:0] ecp,
    input  logic [3:0]  trap_cause,
    input  logic        interupt,
    input  logic [31:0] trap_value,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        soft_irq,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
    output logic        eip,
    output logic        tip,
    output logic        sip,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_vector
);
`ifdef CSR_HPM_EN
    localparam int HPM_IMPL = NUM_HPM;
`else
    localparam int HPM_IMPL = 0;
`endif
    localparam logic [31:0] CNTINH_MASK = 32'h5 | (((32'h1 << HPM_IMPL) - 32'h1) << 3);

    logic        ie, pie, mcause_int, mtvec_vec;
    logic [3:0]  mcause_code;
    logic [29:0] mtvec_base;
    logic [31:0] mie_r, mip_r, mepc, mscratch, mtval, mcountinhibit;
    logic [63:0] cnt_val [32];
    logic        unused_hpm;

    assign unused_hpm = ^hpm_event;

    genvar k;
    generate
        for (k = 0; k < 32; k++) begin : g_cnt
            if (k == 0 || k == 2 || (k >= 3 && k < 3 + HPM_IMPL)) begin : g_impl
                logic inc;
                if (k == 0) begin : g_inc
                    assign inc = 1'b1;
                end else if (k == 2) begin : g_inc
                    assign inc = retired;
                end else begin : g_inc
                    assign inc = hpm_event[k-3];
                end
                csr_counter #(.W(CNT_WIDTH)) u_cnt (
                    .clk       (clk),
                    .reset     (reset),
                    .inc       (inc),
                    .inhibit   (mcountinhibit[k]),
                    .write_lo  (write_enable && write_address == (CSR_MCNT_BASE | 12'(k))),
                    .write_hi  (write_enable && write_address == (CSR_MCNTH_BASE | 12'(k))),
                    .write_data(write_data),
                    .value     (cnt_val[k])
                );
            end else begin : g_none
                assign cnt_val[k] = '0;
            end
        end
    endgenerate

    always_comb begin
        read_data = '0;
        readable  = 1'b1;
        if (is_cnt_addr(read_address)) begin
            readable  = read_address[4:0] != 5'd1;
            read_data = read_address[7] ? cnt_val[read_address[4:0]][63:32]
                                        : cnt_val[read_address[4:0]][31:0];
        end else begin
            case (read_address)
                CSR_MSTATUS: begin
                    read_data[MSTATUS_MIE]  = ie;
                    read_data[MSTATUS_MPIE] = pie;
                end
                CSR_MIE:           read_data = mie_r;
                CSR_MTVEC:         read_data = {mtvec_base, 1'b0, mtvec_vec};
                CSR_MCOUNTINHIBIT: read_data = mcountinhibit;
                CSR_MSCRATCH:      read_data = mscratch;
                CSR_MEPC:          read_data = mepc;
                CSR_MCAUSE:        read_data = {mcause_int, 27'b0, mcause_code};
                CSR_MTVAL:         read_data = mtval;
                CSR_MIP:           read_data = mip_r;
                default: readable = (read_address >= CSR_MHPMEVENT_LO && read_address <= CSR_MHPMEVENT_HI)
                                 || (read_address >= CSR_MID_LO && read_address <= CSR_MID_HI);
            endcase
        end
    end

    assign writeable   = readable && (read_address[11:10] != 2'b11);
    assign eip         = ie & mie_r[CAUSE_MEI] & mip_r[CAUSE_MEI];
    assign tip         = ie & mie_r[CAUSE_MTI] & mip_r[CAUSE_MTI];
    assign sip         = ie & mie_r[CAUSE_MSI] & mip_r[CAUSE_MSI];
    assign mret_vector = mepc;
    assign trap_vector = (mtvec_vec && interupt) ? {mtvec_base, 2'b00} + {26'b0, trap_cause, 2'b00}
                                                 : {mtvec_base, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            ie            <= 1'b0;
            pie           <= 1'b0;
            mie_r         <= '0;
            mip_r         <= '0;
            mtvec_base    <= RESET_VECTOR[31:2];
            mtvec_vec     <= 1'b0;
            mepc          <= '0;
            mscratch      <= '0;
            mtval         <= '0;
            mcause_int    <= 1'b0;
            mcause_code   <= '0;
            mcountinhibit <= '0;
        end else begin
            mip_r            <= '0;
            mip_r[CAUSE_MEI] <= ext_irq;
            mip_r[CAUSE_MTI] <= timer_irq;
            mip_r[CAUSE_MSI] <= soft_irq;
            if (write_enable) begin
                case (write_address)
                    CSR_MIE:           mie_r <= write_data & IRQ_MASK;
                    CSR_MSCRATCH:      mscratch <= write_data;
                    CSR_MCOUNTINHIBIT: mcountinhibit <= write_data & CNTINH_MASK;
                    CSR_MTVEC: begin
                        mtvec_base <= write_data[31:2];
                        // Illegal or unsupported MODE encodings leave the current mode in place.
                        if (write_data[1:0] == 2'b00)              mtvec_vec <= 1'b0;
                        else if (write_data[1:0] == 2'b01 && VECTORED) mtvec_vec <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (traped) begin
                pie         <= ie;
                ie          <= 1'b0;
                mepc        <= ecp;
                mcause_int  <= interupt;
                mcause_code <= trap_cause;
                mtval       <= trap_value;
            end else if (mret) begin
                ie  <= pie;
                pie <= 1'b1;
            end else if (write_enable) begin
                case (write_address)
                    CSR_MSTATUS: begin
                        ie  <= write_data[MSTATUS_MIE];
                        pie <= write_data[MSTATUS_MPIE];
                    end
                    CSR_MEPC:   mepc <= write_data;
                    CSR_MCAUSE: begin
                        mcause_int  <= write_data[31];
                        mcause_code <= write_data[3:0];
                    end
                    CSR_MTVAL:  mtval <= write_data;
                    default: ;
                endcase
            end
        end
    end
endmodule
